// File: rtl/checkers_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checkers_pio_pkg
// Description : Shared register-map addresses, edge-type selectors and the
//               address type for the checkers_pio_ext parallel I/O slave.
// Revision    : 1.0 - initial release
// ============================================================================
package checkers_pio_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA    = 3'd0;
    localparam addr_t ADDR_DIR     = 3'd1;
    localparam addr_t ADDR_IRQMASK = 3'd2;
    localparam addr_t ADDR_EDGECAP = 3'd3;
    localparam addr_t ADDR_OUTSET  = 3'd4;
    localparam addr_t ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage
`default_nettype wire

// File: rtl/checkers_pio_sync.sv
`default_nettype none
// ============================================================================
// Module      : checkers_pio_sync
// Description : WIDTH-bit wide, SYNC_STAGES-deep flop chain bringing an
//               asynchronous bus into the clk domain.
// Ports       : clk     - system clock
//               reset_n - asynchronous active-low reset (chain clears to 0)
//               d_i     - asynchronous input bus
//               q_o     - synchronised output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module checkers_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/checkers_pio_ext.sv
`default_nettype none
// ============================================================================
// Module      : checkers_pio_ext
// Description : Parametrised Avalon-MM parallel I/O slave with input
//               synchroniser, direction register, sticky edge capture,
//               masked level interrupt and optional atomic bit set/clear.
// Build macro : CHECKERS_PIO_SETCLR_EN - when defined, addresses 4/5 perform
//               atomic set/clear of data_out; otherwise they read 0 and
//               ignore writes.
// Ports       : clk, reset_n        - clock, async active-low reset
//               address, chipselect,
//               write_n, writedata  - Avalon-MM slave write/select
//               readdata            - registered read data, 1-cycle latency
//               in_port             - asynchronous external inputs
//               out_port            - data_out register
//               out_en              - direction register (1 = drive)
//               irq                 - level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module checkers_pio_ext
    import checkers_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] w1c_mask;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] wdata;
    logic             wr;
    addr_t            addr;
    logic             unused_wdata;

    assign wr    = chipselect & ~write_n;
    assign addr  = address;
    assign wdata = writedata[WIDTH-1:0];
    // Upper writedata bits are don't-care for narrow instances.
    assign unused_wdata = &{1'b0, writedata};

    checkers_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (in_sync)
    );

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_fall
            assign edge_det = ~in_sync & in_prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
            assign edge_det = in_sync ^ in_prev_q;
        end else begin : g_edge_rise
            assign edge_det = in_sync & ~in_prev_q;
        end
    endgenerate

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_mask_d = irq_mask_q;
        w1c_mask   = '0;
        if (wr) begin
            case (addr)
                ADDR_DATA:    data_out_d = wdata;
                ADDR_DIR:     dir_d      = wdata;
                ADDR_IRQMASK: irq_mask_d = wdata;
                ADDR_EDGECAP: w1c_mask   = wdata;
`ifdef CHECKERS_PIO_SETCLR_EN
                ADDR_OUTSET:  data_out_d = data_out_q | wdata;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wdata;
`endif
                default:      ;
            endcase
        end
        // A new edge on the clear cycle must not be lost, so set wins.
        edge_cap_d = (edge_cap_q & ~w1c_mask) | edge_det;
    end

    // Read mux sampled every clock; address selects the state before the edge.
    always_comb begin
        readdata_d = '0;
        case (addr)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = in_sync;
            ADDR_DIR:     readdata_d[WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_cap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_prev_q  <= '0;
            data_out_q <= RESET_VALUE;
            dir_q      <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
        end else begin
            in_prev_q  <= in_sync;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_out_q;
    assign out_en   = dir_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
`default_nettype wire

// File: tb/tb_checkers_pio_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_checkers_pio_ext
// Description : Self-checking bench for checkers_pio_ext (WIDTH=8,
//               SYNC_STAGES=2, rising edges, RESET_VALUE=8'hA5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_checkers_pio_ext;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RV    = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  out_en;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    checkers_pio_ext #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (0),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_en     (out_en),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] val;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Expected value queued when the read is issued, popped when data returns.
    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        exp_q.push_back(exp);
        address    = a;
        chipselect = 1'b1;
        cyc();
        chipselect = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, readdata);
        end else begin
            e = exp_q.pop_front();
            chk(name, readdata, e);
        end
    endtask

    vec_t rd_tab[8];
    vec_t wr_tab[6];

    initial begin
        // in_prev resets to 0, so bits already high on in_port register as
        // rising edges once the synchroniser fills.
        rd_tab[0] = '{3'd0, 32'h0, 32'h0000_005A, "rst_rd_data"};
        rd_tab[1] = '{3'd1, 32'h0, 32'h0,         "rst_rd_dir"};
        rd_tab[2] = '{3'd2, 32'h0, 32'h0,         "rst_rd_irqmask"};
        rd_tab[3] = '{3'd3, 32'h0, 32'h0000_005A, "rst_rd_edgecap"};
        rd_tab[4] = '{3'd4, 32'h0, 32'h0,         "rst_rd_a4"};
        rd_tab[5] = '{3'd5, 32'h0, 32'h0,         "rst_rd_a5"};
        rd_tab[6] = '{3'd6, 32'h0, 32'h0,         "rst_rd_a6"};
        rd_tab[7] = '{3'd7, 32'h0, 32'h0,         "rst_rd_a7"};

        wr_tab[0] = '{3'd0, 32'h0000_013C, 32'h3C, "wr_data_3c"};
        wr_tab[1] = '{3'd0, 32'hFFFF_FF0F, 32'h0F, "wr_data_0f"};
`ifdef CHECKERS_PIO_SETCLR_EN
        wr_tab[2] = '{3'd4, 32'h0000_00F0, 32'hFF, "wr_outset"};
        wr_tab[3] = '{3'd5, 32'h0000_0081, 32'h7E, "wr_outclr"};
        wr_tab[4] = '{3'd6, 32'h0000_00FF, 32'h7E, "wr_a6_ignored"};
        wr_tab[5] = '{3'd7, 32'h0000_0000, 32'h7E, "wr_a7_ignored"};
`else
        wr_tab[2] = '{3'd4, 32'h0000_00F0, 32'h0F, "wr_outset"};
        wr_tab[3] = '{3'd5, 32'h0000_0081, 32'h0F, "wr_outclr"};
        wr_tab[4] = '{3'd6, 32'h0000_00FF, 32'h0F, "wr_a6_ignored"};
        wr_tab[5] = '{3'd7, 32'h0000_0000, 32'h0F, "wr_a7_ignored"};
`endif

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h5A;
        #12;
        chk("rst_out_port", {24'h0, out_port}, {24'h0, RV});
        chk("rst_out_en",   {24'h0, out_en},   32'h0);
        chk("rst_irq",      {31'h0, irq},      32'h0);
        chk("rst_readdata", readdata,          32'h0);
        cyc();
        reset_n = 1'b1;
        repeat (4) cyc();

        for (int i = 0; i < 8; i++) begin
            bus_read(rd_tab[i].addr, rd_tab[i].exp, rd_tab[i].name);
        end
        chk("rst_out_port_after_reads", {24'h0, out_port}, {24'h0, RV});

        bus_write(3'd3, 32'hFF);
        bus_read(3'd3, 32'h0, "edgecap_cleared");

        for (int i = 0; i < 6; i++) begin
            bus_write(wr_tab[i].addr, wr_tab[i].val);
            chk(wr_tab[i].name, {24'h0, out_port}, {24'h0, wr_tab[i].exp});
            if (i == 0) bus_read(3'd0, 32'h5A, "rd_data_is_in_sync");
        end
        bus_read(3'd4, 32'h0, "rd_outset_zero");

        bus_write(3'd1, 32'h33);
        bus_read(3'd1, 32'h33, "rd_dir");
        chk("out_en_33", {24'h0, out_en}, 32'h33);
        chk("out_port_indep_dir", {24'h0, out_port}, {24'h0, wr_tab[5].exp});

        bus_write(3'd2, 32'h04);
        bus_read(3'd2, 32'h04, "rd_irqmask");
        chk("irq_idle", {31'h0, irq}, 32'h0);

        // Rising edge on bit 2: capture and irq exactly at the third edge.
        in_port = 8'h5E;
        cyc();
        chk("irq_e1", {31'h0, irq}, 32'h0);
        cyc();
        chk("irq_e2", {31'h0, irq}, 32'h0);
        cyc();
        chk("irq_e3", {31'h0, irq}, 32'h1);
        bus_read(3'd3, 32'h04, "edgecap_rise");
        bus_write(3'd3, 32'h04);
        chk("irq_after_w1c", {31'h0, irq}, 32'h0);

        // Falling edge must not capture.
        in_port = 8'h5A;
        repeat (5) cyc();
        chk("irq_fall", {31'h0, irq}, 32'h0);
        bus_read(3'd3, 32'h0, "edgecap_fall");

        // Set wins over a simultaneous write-1-to-clear.
        in_port = 8'h5E;
        repeat (3) cyc();
        chk("pending_irq", {31'h0, irq}, 32'h1);
        in_port = 8'h5A;
        repeat (2) cyc();
        in_port = 8'h5E;
        repeat (2) cyc();
        bus_write(3'd3, 32'h04);
        chk("setwins_irq", {31'h0, irq}, 32'h1);
        bus_write(3'd3, 32'h04);
        chk("w1c_noedge_irq", {31'h0, irq}, 32'h0);
        bus_read(3'd3, 32'h0, "edgecap_after_w1c");

        // Load everything, then pull reset between clock edges.
        bus_write(3'd1, 32'hFF);
        bus_write(3'd2, 32'hFF);
        in_port = 8'h00;
        repeat (4) cyc();
        in_port = 8'hFF;
        repeat (4) cyc();
        chk("irq_all", {31'h0, irq}, 32'h1);
        bus_read(3'd3, 32'hFF, "edgecap_ff");
        address = 3'd3;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_irq",      {31'h0, irq},      32'h0);
        chk("async_out_port", {24'h0, out_port}, {24'h0, RV});
        chk("async_out_en",   {24'h0, out_en},   32'h0);
        chk("async_readdata", readdata,          32'h0);
        cyc();
        reset_n = 1'b1;
        bus_read(3'd2, 32'h0, "irqmask_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
